// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - shared constants, block-FSM states and write-size encoding for dmem_block_responder
package dmem_resp_pkg;

    localparam int BLK_BYTES     = 32;
    localparam int WORDS_PER_BLK = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } blk_state_e;

    localparam logic [1:0] SZ_4 = 2'd0;
    localparam logic [1:0] SZ_1 = 2'd1;
    localparam logic [1:0] SZ_2 = 2'd2;
    localparam logic [1:0] SZ_3 = 2'd3;

    // Number of bytes a write-size code stands for (code 0 means a full word)
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        return (sz == SZ_4) ? 3'd4 : {1'b0, sz};
    endfunction

endpackage

// File: rtl/dmem_blk_fsm.sv
// rtl/dmem_blk_fsm.sv - block request latching, write priority, latency counter and valid generation
module dmem_blk_fsm
    import dmem_resp_pkg::*;
#(
    parameter int BLK_LATENCY = 4,
    parameter int BAW         = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_rd,
    input  logic           req_wr,
    input  logic [BAW-1:0] req_addr,
    output logic           accept,
    output logic           commit,
    output logic           capture,
    output logic [BAW-1:0] op_addr,
    output logic           rd_valid,
    output logic           wr_valid
);

    localparam int            CW       = (BLK_LATENCY > 1) ? $clog2(BLK_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(BLK_LATENCY - 1);

    blk_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           op_wr_q, op_wr_d;
    logic [BAW-1:0] addr_q, addr_d;
    logic           rd_valid_q, rd_valid_d;
    logic           wr_valid_q, wr_valid_d;
    logic           req_live;

    // Next-state logic; the request that started the operation must stay high or the op is dropped
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        addr_d     = addr_q;
        rd_valid_d = rd_valid_q;
        wr_valid_d = wr_valid_q;
        accept     = 1'b0;
        commit     = 1'b0;
        capture    = 1'b0;
        req_live   = op_wr_q ? req_wr : req_rd;
        case (state_q)
            ST_IDLE: begin
                if (req_wr || req_rd) begin
                    accept  = 1'b1;
                    op_wr_d = req_wr;
                    addr_d  = req_addr;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!req_live) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    commit     = op_wr_q;
                    capture    = !op_wr_q;
                    wr_valid_d = op_wr_q;
                    rd_valid_d = !op_wr_q;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                if (!req_live) begin
                    rd_valid_d = 1'b0;
                    wr_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                rd_valid_d = 1'b0;
                wr_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // FSM state, counter, latched op and registered valids
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            addr_q     <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            addr_q     <= addr_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
        end
    end

    assign op_addr  = addr_q;
    assign rd_valid = rd_valid_q;
    assign wr_valid = wr_valid_q;

endmodule

// File: rtl/dmem_block_responder.sv
// rtl/dmem_block_responder.sv - data-memory responder: word path plus latency-counted block path; optional DMEM_RESP_ALIGN_CHK_EN adds align_err
module dmem_block_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int BLK_LATENCY = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  data_address_2DM,
    input  logic         MemRead_2DM,
    input  logic         MemWrite_2DM,
    input  logic [31:0]  data_write_2DM,
    input  logic [1:0]   data_write_size_2DM,
    output logic [31:0]  data_read_fDM,
    input  logic [255:0] block_write_2DM,
    input  logic         dBlkRead,
    input  logic         dBlkWrite,
    output logic [255:0] block_read_fDM,
    output logic         block_read_fDM_valid,
    output logic         block_write_fDM_valid
`ifdef DMEM_RESP_ALIGN_CHK_EN
    ,
    output logic         align_err
`endif
);

    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int BAW = AW - 3;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [AW-1:0]  widx;
    logic [1:0]     lane_off;
    logic [31:0]    word_wr_d;
    int             nbytes;
    int             k;
    logic           blk_accept, blk_commit, blk_capture;
    logic [BAW-1:0] blk_base;
    logic [255:0]   blk_wdata_q, blk_wdata_d;
    logic [255:0]   blk_rdata_q, blk_rdata_d;
    logic           unused_addr_hi;

    assign widx           = data_address_2DM[AW+1:2];
    assign lane_off       = data_address_2DM[1:0];
    assign unused_addr_hi = ^data_address_2DM[31:AW+2];
    assign data_read_fDM  = MemRead_2DM ? mem[widx] : '0;

    dmem_blk_fsm #(
        .BLK_LATENCY(BLK_LATENCY),
        .BAW        (BAW)
    ) u_fsm (
        .clk     (CLK),
        .rst_n   (RESET),
        .req_rd  (dBlkRead),
        .req_wr  (dBlkWrite),
        .req_addr(data_address_2DM[AW+1:5]),
        .accept  (blk_accept),
        .commit  (blk_commit),
        .capture (blk_capture),
        .op_addr (blk_base),
        .rd_valid(block_read_fDM_valid),
        .wr_valid(block_write_fDM_valid)
    );

    // Byte-lane merge: big-endian lanes, low bytes of the write data land from lane_off upward
    always_comb begin
        nbytes    = int'(size_bytes(data_write_size_2DM));
        k         = 0;
        word_wr_d = mem[widx];
        for (int l = 0; l < 4; l++) begin
            k = l - int'(lane_off);
            if (k >= 0 && k < nbytes) begin
                word_wr_d[31 - 8*l -: 8] = data_write_2DM[8*(nbytes - 1 - k) +: 8];
            end
        end
    end

    // Storage: word write first so a same-edge block commit overrides the overlapping word
    always_ff @(posedge CLK) begin
        if (MemWrite_2DM) begin
            mem[widx] <= word_wr_d;
        end
        if (blk_commit) begin
            for (int i = 0; i < WORDS_PER_BLK; i++) begin
                mem[{blk_base, 3'(i)}] <= blk_wdata_q[255 - 32*i -: 32];
            end
        end
    end

    // Block write data is latched at acceptance; read data is captured from storage on completion
    always_comb begin
        blk_wdata_d = blk_wdata_q;
        blk_rdata_d = blk_rdata_q;
        if (blk_accept && dBlkWrite) begin
            blk_wdata_d = block_write_2DM;
        end
        if (blk_capture) begin
            for (int i = 0; i < WORDS_PER_BLK; i++) begin
                blk_rdata_d[255 - 32*i -: 32] = mem[{blk_base, 3'(i)}];
            end
        end
    end

    // Block data registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            blk_wdata_q <= '0;
            blk_rdata_q <= '0;
        end else begin
            blk_wdata_q <= blk_wdata_d;
            blk_rdata_q <= blk_rdata_d;
        end
    end

    assign block_read_fDM = blk_rdata_q;

`ifdef DMEM_RESP_ALIGN_CHK_EN
    localparam int OFF_W = $clog2(BLK_BYTES);

    logic align_err_q, align_err_d;
    logic bytes_dropped;

    // Sticky misalignment flag: misaligned read, truncated write, or unaligned block accept
    always_comb begin
        bytes_dropped = (int'(lane_off) + nbytes) > 4;
        align_err_d   = align_err_q
                      | (MemRead_2DM && (lane_off != 2'd0))
                      | (MemWrite_2DM && bytes_dropped)
                      | (blk_accept && (data_address_2DM[OFF_W-1:0] != '0));
    end

    // Flag register, cleared only by reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign align_err = align_err_q;
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// tb/tb_dmem_block_responder.sv - table-driven word vectors plus block-path corner sequences for dmem_block_responder
module tb_dmem_block_responder;

    localparam int LAT = 4;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [31:0]  data_address_2DM = '0;
    logic         MemRead_2DM = 1'b0;
    logic         MemWrite_2DM = 1'b0;
    logic [31:0]  data_write_2DM = '0;
    logic [1:0]   data_write_size_2DM = '0;
    logic [31:0]  data_read_fDM;
    logic [255:0] block_write_2DM = '0;
    logic         dBlkRead = 1'b0;
    logic         dBlkWrite = 1'b0;
    logic [255:0] block_read_fDM;
    logic         block_read_fDM_valid;
    logic         block_write_fDM_valid;
`ifdef DMEM_RESP_ALIGN_CHK_EN
    logic         align_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    dmem_block_responder #(.DEPTH_WORDS(4096), .BLK_LATENCY(LAT)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .data_address_2DM     (data_address_2DM),
        .MemRead_2DM          (MemRead_2DM),
        .MemWrite_2DM         (MemWrite_2DM),
        .data_write_2DM       (data_write_2DM),
        .data_write_size_2DM  (data_write_size_2DM),
        .data_read_fDM        (data_read_fDM),
        .block_write_2DM      (block_write_2DM),
        .dBlkRead             (dBlkRead),
        .dBlkWrite            (dBlkWrite),
        .block_read_fDM       (block_read_fDM),
        .block_read_fDM_valid (block_read_fDM_valid),
        .block_write_fDM_valid(block_write_fDM_valid)
`ifdef DMEM_RESP_ALIGN_CHK_EN
        ,
        .align_err            (align_err)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  sz;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic word_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        data_address_2DM    = a;
        data_write_2DM      = d;
        data_write_size_2DM = sz;
        MemWrite_2DM        = 1'b1;
        tick();
        MemWrite_2DM        = 1'b0;
    endtask

    task automatic word_read_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        data_address_2DM = a;
        MemRead_2DM      = 1'b1;
        #1;
        chk(nm, {224'd0, data_read_fDM}, {224'd0, exp});
        MemRead_2DM      = 1'b0;
    endtask

    function automatic logic [255:0] blk_of(input logic [31:0] base);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[255 - 32*i -: 32] = base + 32'(i);
        return v;
    endfunction

    // Full block operation with the request held through completion, then released
    task automatic blk_op(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [255:0] wd, input logic [255:0] exp_rd);
        data_address_2DM = a;
        block_write_2DM  = wd;
        dBlkRead         = rd;
        dBlkWrite        = wr;
        tick();
        for (int e = 1; e <= LAT; e++) begin
            tick();
            chk($sformatf("%s_rv_e%0d", nm, e), {255'd0, block_read_fDM_valid}, {255'd0, (e == LAT) && !wr});
            chk($sformatf("%s_wv_e%0d", nm, e), {255'd0, block_write_fDM_valid}, {255'd0, (e == LAT) && wr});
        end
        if (!wr) chk({nm, "_data"}, block_read_fDM, exp_rd);
        tick();
        chk({nm, "_hold"}, {255'd0, block_read_fDM_valid | block_write_fDM_valid}, 256'd1);
        if (!wr) chk({nm, "_hold_data"}, block_read_fDM, exp_rd);
        dBlkRead  = 1'b0;
        dBlkWrite = 1'b0;
        tick();
        chk({nm, "_release"}, {254'd0, block_read_fDM_valid, block_write_fDM_valid}, 256'd0);
    endtask

    task automatic reset_pulse_chk(input string nm);
        #2 RESET = 1'b0;
        #1;
        chk({nm, "_valids"}, {254'd0, block_read_fDM_valid, block_write_fDM_valid}, 256'd0);
        chk({nm, "_rdata"}, block_read_fDM, 256'd0);
        dBlkRead  = 1'b0;
        dBlkWrite = 1'b0;
        #2 RESET = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{32'h100,  1'b0, 1'b1, 32'hAABBCCDD, 2'd0, 32'h0};
        vecs[1]  = '{32'h100,  1'b1, 1'b0, 32'h0,        2'd0, 32'hAABBCCDD};
        vecs[2]  = '{32'h101,  1'b0, 1'b1, 32'h000000EE, 2'd1, 32'h0};
        vecs[3]  = '{32'h100,  1'b1, 1'b0, 32'h0,        2'd0, 32'hAAEECCDD};
        vecs[4]  = '{32'h102,  1'b0, 1'b1, 32'h00001234, 2'd2, 32'h0};
        vecs[5]  = '{32'h100,  1'b1, 1'b0, 32'h0,        2'd0, 32'hAAEE1234};
        vecs[6]  = '{32'h103,  1'b0, 1'b1, 32'h00ABCDEF, 2'd3, 32'h0};
        vecs[7]  = '{32'h100,  1'b1, 1'b0, 32'h0,        2'd0, 32'hAAEE12AB};
        vecs[8]  = '{32'h4104, 1'b0, 1'b1, 32'h55667788, 2'd0, 32'h0};
        vecs[9]  = '{32'h104,  1'b1, 1'b0, 32'h0,        2'd0, 32'h55667788};
        vecs[10] = '{32'h101,  1'b0, 1'b1, 32'h00C0FFEE, 2'd3, 32'h0};
        vecs[11] = '{32'h100,  1'b1, 1'b0, 32'h0,        2'd0, 32'hAAC0FFEE};
        vecs[12] = '{32'h100,  1'b0, 1'b0, 32'h0,        2'd0, 32'h0};
        vecs[13] = '{32'h4100, 1'b1, 1'b0, 32'h0,        2'd0, 32'hAAC0FFEE};

        #2;
        chk("reset_valids", {254'd0, block_read_fDM_valid, block_write_fDM_valid}, 256'd0);
        chk("reset_rdata", block_read_fDM, 256'd0);
`ifdef DMEM_RESP_ALIGN_CHK_EN
        chk("reset_align", {255'd0, align_err}, 256'd0);
`endif
        #10 RESET = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            data_address_2DM    = vecs[i].addr;
            MemRead_2DM         = vecs[i].rd;
            MemWrite_2DM        = vecs[i].wr;
            data_write_2DM      = vecs[i].wdata;
            data_write_size_2DM = vecs[i].sz;
            #1;
            chk($sformatf("vec%0d", i), {224'd0, data_read_fDM}, {224'd0, vecs[i].exp});
            if (vecs[i].wr) tick();
            MemRead_2DM  = 1'b0;
            MemWrite_2DM = 1'b0;
        end

        for (int i = 0; i < 8; i++) word_write(32'h200 + 32'(4*i), 32'hB0000000 + 32'(i), 2'd0);
        blk_op("blkrd200", 1'b1, 1'b0, 32'h200, 256'd0, blk_of(32'hB0000000));

        blk_op("blkboth400", 1'b1, 1'b1, 32'h400, blk_of(32'hC0000000), 256'd0);
        word_read_chk("w404_after_blkwr", 32'h404, 32'hC0000001);
        blk_op("blkrd400", 1'b1, 1'b0, 32'h400, 256'd0, blk_of(32'hC0000000));

        word_write(32'h600, 32'h12345678, 2'd0);
        data_address_2DM = 32'h600;
        block_write_2DM  = blk_of(32'hD0000000);
        dBlkWrite        = 1'b1;
        tick();
        tick();
        tick();
        dBlkWrite = 1'b0;
        tick();
        for (int e = 0; e < 4; e++) begin
            chk($sformatf("abort_wv%0d", e), {255'd0, block_write_fDM_valid}, 256'd0);
            tick();
        end
        word_read_chk("abort_mem_kept", 32'h600, 32'h12345678);
        word_read_chk("abort_mem_kept1", 32'h604, 32'h0000_0000 | dut.mem[12'h181]);
        blk_op("after_abort", 1'b1, 1'b0, 32'h600, 256'd0,
               {32'h12345678, dut.mem[12'h181], dut.mem[12'h182], dut.mem[12'h183],
                dut.mem[12'h184], dut.mem[12'h185], dut.mem[12'h186], dut.mem[12'h187]});

        word_write(32'h800, 32'h0BADF00D, 2'd0);
        data_address_2DM = 32'h800;
        block_write_2DM  = blk_of(32'hE0000000);
        dBlkWrite        = 1'b1;
        tick();
        tick();
        reset_pulse_chk("rst_busy");
        for (int e = 0; e < LAT + 2; e++) tick();
        chk("rst_busy_no_commit_v", {255'd0, block_write_fDM_valid}, 256'd0);
        word_read_chk("rst_busy_mem800", 32'h800, 32'h0BADF00D);
        word_read_chk("rst_busy_mem100", 32'h100, 32'hAAC0FFEE);

        data_address_2DM = 32'h200;
        dBlkRead         = 1'b1;
        for (int e = 0; e <= LAT; e++) tick();
        chk("rst_done_pre", {255'd0, block_read_fDM_valid}, 256'd1);
        reset_pulse_chk("rst_done");
        tick();
        blk_op("post_reset_rd", 1'b1, 1'b0, 32'h200, 256'd0, blk_of(32'hB0000000));

`ifdef DMEM_RESP_ALIGN_CHK_EN
        reset_pulse_chk("align_clear");
        tick();
        chk("align_cleared", {255'd0, align_err}, 256'd0);
        data_address_2DM = 32'h102;
        MemRead_2DM      = 1'b1;
        #1;
        chk("align_pre_edge", {255'd0, align_err}, 256'd0);
        tick();
        MemRead_2DM = 1'b0;
        chk("align_set", {255'd0, align_err}, 256'd1);
        tick();
        tick();
        chk("align_sticky", {255'd0, align_err}, 256'd1);
        reset_pulse_chk("align_rst");
        chk("align_after_rst", {255'd0, align_err}, 256'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
